// File: rtl/fp_norm_round_pack_if.sv
// Format type and valid/ready bundle for the FP32 / dual-FP16 normalize-round-pack stage.
// The package sits here so the format enum is visible to the interface, the block and its users.
package fp_norm_round_pack_pkg;
  typedef enum logic {
    FMT_FP32 = 1'b0,
    FMT_FP16 = 1'b1
  } fp_fmt_e;
endpackage

interface fp_norm_round_pack_if;
  logic                             in_valid;
  logic                             in_ready;
  fp_norm_round_pack_pkg::fp_fmt_e  fmt;
  logic [27:0]                      X;
  logic [7:0]                       exp_h;
  logic [7:0]                       exp_l;
  logic                             sign_h;
  logic                             sign_l;
  logic                             Sticky_h;
  logic                             Sticky_l;
  logic                             out_valid;
  logic                             out_ready;
  logic [31:0]                      R;
  logic [2:0]                       flags_h;
  logic [2:0]                       flags_l;

  modport master (
    output in_valid, fmt, X, exp_h, exp_l, sign_h, sign_l, Sticky_h, Sticky_l, out_ready,
    input  in_ready, out_valid, R, flags_h, flags_l
  );

  modport slave (
    input  in_valid, fmt, X, exp_h, exp_l, sign_h, sign_l, Sticky_h, Sticky_l, out_ready,
    output in_ready, out_valid, R, flags_h, flags_l
  );
endinterface

// File: rtl/fp_norm_round_pack.sv
// Output end of the shared FP32 / dual-FP16 add datapath: normalize the raw 28-bit
// post-add mantissa, round (RNE or truncate), and pack IEEE results with {ovf, unf, inx}.
// Valid/ready pipeline, one beat per cycle. Defining FP_NORM_ROUND_PACK_OUT_REG_EN adds a
// third registered stage in front of the outputs (latency 3 instead of 2, same results).
module fp_norm_round_pack
  import fp_norm_round_pack_pkg::*;
#(
  parameter int ROUND_RNE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_norm_round_pack_if.slave  bus
);

  localparam logic RNE_EN = (ROUND_RNE != 0);

  // Leading-zero count over 28 bits; an all-zero input saturates at 28.
  function automatic logic [4:0] lzc28(input logic [27:0] x);
    logic [4:0] n;
    logic       found;
    n     = 5'd28;
    found = 1'b0;
    for (int i = 27; i >= 0; i--) begin
      if (!found && x[i]) begin
        n     = 5'(27 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Leading-zero count over one 14-bit FP16 lane; an all-zero lane saturates at 14.
  function automatic logic [3:0] lzc14(input logic [13:0] x);
    logic [3:0] n;
    logic       found;
    n     = 4'd14;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found && x[i]) begin
        n     = 4'(13 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Round and pack one FP32 value from a normalized mantissa (hidden bit above m[26]).
  // Returns {ovf, unf, inx, result[31:0]}.
  function automatic logic [34:0] round_fp32(input logic s, input logic [26:0] m,
                                             input logic signed [9:0] e,
                                             input logic stk, input logic zero);
    logic               guard;
    logic               st;
    logic               inc;
    logic [23:0]        sum;
    logic signed [9:0]  er;
    guard = m[3];
    st    = (|m[2:0]) | stk;
    inc   = RNE_EN && guard && (st || m[4]);
    sum   = {1'b0, m[26:4]} + {23'd0, inc};
    er    = e + (sum[23] ? 10'sd1 : 10'sd0);
    if (zero)                return {3'b000, s, 31'd0};
    else if (er >= 10'sd255) return {3'b101, s, 8'hFF, 23'd0};
    else if (er <= 10'sd0)   return {3'b011, s, 31'd0};
    else                     return {2'b00, guard | st, s, er[7:0], sum[22:0]};
  endfunction

  // Round and pack one FP16 lane from a normalized mantissa (hidden bit above m[12]).
  // Returns {ovf, unf, inx, result[15:0]}.
  function automatic logic [18:0] round_fp16(input logic s, input logic [12:0] m,
                                             input logic signed [6:0] e,
                                             input logic stk, input logic zero);
    logic               guard;
    logic               st;
    logic               inc;
    logic [10:0]        sum;
    logic signed [6:0]  er;
    guard = m[2];
    st    = (|m[1:0]) | stk;
    inc   = RNE_EN && guard && (st || m[3]);
    sum   = {1'b0, m[12:3]} + {10'd0, inc};
    er    = e + (sum[10] ? 7'sd1 : 7'sd0);
    if (zero)              return {3'b000, s, 15'd0};
    else if (er >= 7'sd31) return {3'b101, s, 5'h1F, 10'd0};
    else if (er <= 7'sd0)  return {3'b011, s, 15'd0};
    else                   return {2'b00, guard | st, s, er[4:0], sum[9:0]};
  endfunction

  // Handshake control
  logic vld_p1;
  logic vld_p2;
  logic adv_p2;
  logic load_p1;

  // Stage 1 (normalize) next-state values
  logic [4:0]        lz32;
  logic [3:0]        lz_h;
  logic [3:0]        lz_l;
  logic [27:0]       mant_n;
  logic signed [6:0] e_h_n;
  logic signed [9:0] e_l_n;
  logic              zero_h_n;
  logic              zero_l_n;

  // Stage 1 registers
  fp_fmt_e           fmt_p1;
  logic [27:0]       mant_p1;
  logic signed [6:0] e_h_p1;
  logic signed [9:0] e_l_p1;
  logic              sign_h_p1;
  logic              sign_l_p1;
  logic              stk_h_p1;
  logic              stk_l_p1;
  logic              zero_h_p1;
  logic              zero_l_p1;

  // Stage 2 (round/pack) values and registers
  logic [34:0]       res32;
  logic [18:0]       res_h;
  logic [18:0]       res_l;
  logic [31:0]       r_n;
  logic [2:0]        fh_n;
  logic [2:0]        fl_n;
  logic [31:0]       r_p2;
  logic [2:0]        fh_p2;
  logic [2:0]        fl_p2;

  // Bits that the format never consults: exp_h above the FP16 field, and the
  // post-normalize leading 1 of the full word (it is the implied hidden bit).
  logic unused_bits;
  assign unused_bits = ^{bus.exp_h[7:5], mant_p1[27]};

  // Normalize: per-format leading-zero count, left shift, and exponent adjust.
  always_comb begin
    lz32     = lzc28(bus.X);
    lz_h     = lzc14(bus.X[27:14]);
    lz_l     = lzc14(bus.X[13:0]);
    mant_n   = bus.X << lz32;
    e_l_n    = $signed({2'b00, bus.exp_l}) + 10'sd1 - $signed({5'b00000, lz32});
    zero_l_n = (bus.X == 28'd0);
    e_h_n    = $signed({2'b00, bus.exp_h[4:0]}) + 7'sd1 - $signed({3'b000, lz_h});
    zero_h_n = (bus.X[27:14] == 14'd0);
    if (bus.fmt == FMT_FP16) begin
      mant_n   = {bus.X[27:14] << lz_h, bus.X[13:0] << lz_l};
      e_l_n    = $signed({5'b00000, bus.exp_l[4:0]}) + 10'sd1 - $signed({6'b000000, lz_l});
      zero_l_n = (bus.X[13:0] == 14'd0);
    end
  end

  // Round and pack both formats from stage 1; the beat's format picks the result.
  always_comb begin
    res32 = round_fp32(sign_l_p1, mant_p1[26:0], e_l_p1, stk_l_p1, zero_l_p1);
    res_h = round_fp16(sign_h_p1, mant_p1[26:14], e_h_p1, stk_h_p1, zero_h_p1);
    res_l = round_fp16(sign_l_p1, mant_p1[12:0], e_l_p1[6:0], stk_l_p1, zero_l_p1);
    r_n   = res32[31:0];
    fh_n  = 3'b000;
    fl_n  = res32[34:32];
    if (fmt_p1 == FMT_FP16) begin
      r_n  = {res_h[15:0], res_l[15:0]};
      fh_n = res_h[18:16];
      fl_n = res_l[18:16];
    end
  end

`ifdef FP_NORM_ROUND_PACK_OUT_REG_EN
  logic        vld_p3;
  logic        adv_p3;
  logic [31:0] r_p3;
  logic [2:0]  fh_p3;
  logic [2:0]  fl_p3;

  assign adv_p3 = !vld_p3 || bus.out_ready;
  assign adv_p2 = !vld_p2 || adv_p3;

  // Output stage valid bit: cleared by reset, refilled from stage 2 when it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p3 <= 1'b0;
    end else if (adv_p3) begin
      vld_p3 <= vld_p2;
    end
  end

  // Output stage data: captured only when a valid stage-2 beat moves forward.
  always_ff @(posedge clk) begin
    if (adv_p3 && vld_p2) begin
      r_p3  <= r_p2;
      fh_p3 <= fh_p2;
      fl_p3 <= fl_p2;
    end
  end

  assign bus.out_valid = vld_p3;
  assign bus.R         = vld_p3 ? r_p3  : 32'd0;
  assign bus.flags_h   = vld_p3 ? fh_p3 : 3'b000;
  assign bus.flags_l   = vld_p3 ? fl_p3 : 3'b000;
`else
  assign adv_p2 = !vld_p2 || bus.out_ready;

  assign bus.out_valid = vld_p2;
  assign bus.R         = vld_p2 ? r_p2  : 32'd0;
  assign bus.flags_h   = vld_p2 ? fh_p2 : 3'b000;
  assign bus.flags_l   = vld_p2 ? fl_p2 : 3'b000;
`endif

  assign load_p1      = !vld_p1 || adv_p2;
  assign bus.in_ready = load_p1;

  // Stage valid bits: reset empties the pipe; each stage refills when it can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (load_p1) vld_p1 <= bus.in_valid;
      if (adv_p2)  vld_p2 <= vld_p1;
    end
  end

  // ---- stage 0 -> 1 boundary: capture the normalized beat ----
  always_ff @(posedge clk) begin
    if (load_p1 && bus.in_valid) begin
      fmt_p1    <= bus.fmt;
      mant_p1   <= mant_n;
      e_h_p1    <= e_h_n;
      e_l_p1    <= e_l_n;
      sign_h_p1 <= bus.sign_h;
      sign_l_p1 <= bus.sign_l;
      stk_h_p1  <= bus.Sticky_h;
      stk_l_p1  <= bus.Sticky_l;
      zero_h_p1 <= zero_h_n;
      zero_l_p1 <= zero_l_n;
    end
  end

  // ---- stage 1 -> 2 boundary: capture the packed result and flags ----
  always_ff @(posedge clk) begin
    if (adv_p2 && vld_p1) begin
      r_p2  <= r_n;
      fh_p2 <= fh_n;
      fl_p2 <= fl_n;
    end
  end

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Bench for fp_norm_round_pack: fixed vectors, backpressure, mid-stream reset, and
// randomized traffic scored against an arithmetic reference model.
module tb_fp_norm_round_pack;
  import fp_norm_round_pack_pkg::*;

`ifdef FP_NORM_ROUND_PACK_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_norm_round_pack_if bus();

  fp_norm_round_pack #(.ROUND_RNE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    fp_fmt_e     fmt;
    logic [27:0] x;
    logic [7:0]  eh;
    logic [7:0]  el;
    logic        sh;
    logic        sl;
    logic        sth;
    logic        stl;
    logic [31:0] r;
    logic [2:0]  fh;
    logic [2:0]  fl;
  } beat_t;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  fh;
    logic [2:0]  fl;
    int          acc;
  } exp_t;

  beat_t stimq[$];
  exp_t  expq[$];
  beat_t tbl[11];

  int    errors  = 0;
  int    checks  = 0;
  int    cyc     = 0;
  int    acc_cnt = 0;
  int    gap_pct = 0;
  logic  or_val  = 1'b1;
  bit    chk_lat = 1'b0;
  string tag     = "init";
  logic        stall_prev = 1'b0;
  logic [31:0] r_prev;
  logic [5:0]  f_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: value-level normalize/round of one lane. w = mantissa width, fb = fraction bits.
  // The significand is cut to fb bits below its leading 1 and the discarded remainder is
  // compared against one half ULP (sticky counts as a tiny extra amount below it).
  function automatic logic [34:0] model_lane(input int w, input int fb, input int emax,
                                             input longint m, input int ex,
                                             input logic s, input logic stk);
    int     ebits, p, sh, e;
    longint kept, rem, half, res;
    logic   up, inx;
    logic [2:0] fl;
    ebits = (fb == 23) ? 8 : 5;
    res   = longint'(s) << (ebits + fb);
    if (m == 0) return {3'b000, res[31:0]};
    p = 0;
    for (int i = 0; i < w; i++) if (m[i]) p = i;
    e  = ex + p - (w - 2);
    sh = p - fb;
    if (sh > 0) begin
      kept = m >> sh;
      rem  = m - (kept << sh);
      half = longint'(1) << (sh - 1);
    end else begin
      kept = m << (-sh);
      rem  = 0;
      half = 1;
    end
    inx = (rem != 0) || stk;
    up  = (rem > half) || ((rem == half) && (stk || kept[0]));
    if (up) kept = kept + 1;
    if (kept == (longint'(1) << (fb + 1))) begin
      kept = kept >> 1;
      e    = e + 1;
    end
    if (e >= emax) begin
      res = res | (((longint'(1) << ebits) - 1) << fb);
      fl  = 3'b101;
    end else if (e <= 0) begin
      fl = 3'b011;
    end else begin
      res = res | (longint'(e) << fb) | (kept & ((longint'(1) << fb) - 1));
      fl  = {2'b00, inx};
    end
    return {fl, res[31:0]};
  endfunction

  function automatic beat_t mk_rand();
    beat_t b;
    logic [34:0] m32, mh, ml;
    b.fmt = ($urandom_range(0, 1) == 1) ? FMT_FP16 : FMT_FP32;
    b.eh  = 8'($urandom);
    b.el  = 8'($urandom);
    b.sh  = 1'($urandom);
    b.sl  = 1'($urandom);
    b.sth = 1'($urandom);
    b.stl = 1'($urandom);
    if (b.fmt == FMT_FP16) begin
      b.x  = {14'($urandom) >> $urandom_range(0, 14), 14'($urandom) >> $urandom_range(0, 14)};
      mh   = model_lane(14, 10, 31, longint'(b.x[27:14]), int'(b.eh[4:0]), b.sh, b.sth);
      ml   = model_lane(14, 10, 31, longint'(b.x[13:0]), int'(b.el[4:0]), b.sl, b.stl);
      b.r  = {mh[15:0], ml[15:0]};
      b.fh = mh[34:32];
      b.fl = ml[34:32];
    end else begin
      b.x  = 28'($urandom) >> $urandom_range(0, 28);
      m32  = model_lane(28, 23, 255, longint'(b.x), int'(b.el), b.sl, b.stl);
      b.r  = m32[31:0];
      b.fh = 3'b000;
      b.fl = m32[34:32];
    end
    return b;
  endfunction

  function automatic beat_t vec(input fp_fmt_e f, input logic [27:0] x, input logic [7:0] eh,
                                input logic [7:0] el, input logic sh, input logic sl,
                                input logic sth, input logic stl, input logic [31:0] r,
                                input logic [2:0] fh, input logic [2:0] fl);
    beat_t b;
    b.fmt = f;  b.x = x;  b.eh = eh;  b.el = el;  b.sh = sh;  b.sl = sl;
    b.sth = sth; b.stl = stl; b.r = r; b.fh = fh; b.fl = fl;
    return b;
  endfunction

  // One clock: drive at the falling edge, evaluate handshakes just after it.
  task automatic cycle();
    exp_t  e;
    beat_t b;
    @(negedge clk);
    cyc++;
    bus.out_ready = or_val;
    if (stimq.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
      bus.in_valid = 1'b1;
      bus.fmt      = stimq[0].fmt;
      bus.X        = stimq[0].x;
      bus.exp_h    = stimq[0].eh;
      bus.exp_l    = stimq[0].el;
      bus.sign_h   = stimq[0].sh;
      bus.sign_l   = stimq[0].sl;
      bus.Sticky_h = stimq[0].sth;
      bus.Sticky_l = stimq[0].stl;
    end else begin
      bus.in_valid = 1'b0;
    end
    #1;
    if (stall_prev) begin
      chk({tag, ":hold_valid"}, bus.out_valid, 1'b1);
      chk({tag, ":hold_data"}, {bus.R, bus.flags_h, bus.flags_l}, {r_prev, f_prev});
    end
    if (bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        chk({tag, ":spurious_out"}, bus.out_valid, 1'b0);
      end else begin
        e = expq.pop_front();
        chk({tag, ":R"}, bus.R, e.r);
        chk({tag, ":flags"}, {bus.flags_h, bus.flags_l}, {e.fh, e.fl});
        if (chk_lat) chk({tag, ":latency"}, 64'(cyc - e.acc), 64'(LAT));
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      b = stimq.pop_front();
      expq.push_back('{b.r, b.fh, b.fl, cyc});
      acc_cnt++;
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    r_prev     = bus.R;
    f_prev     = {bus.flags_h, bus.flags_l};
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while ((stimq.size() != 0 || expq.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, ":drain_left"}, 64'(stimq.size() + expq.size()), 64'd0);
  endtask

  initial begin
    tbl[0]  = vec(FMT_FP32, 28'h4000000, 8'd0, 8'd127, 0, 0, 0, 0, 32'h3F800000, 3'b000, 3'b000);
    tbl[1]  = vec(FMT_FP32, 28'h8000000, 8'd0, 8'd127, 0, 0, 0, 0, 32'h40000000, 3'b000, 3'b000);
    tbl[2]  = vec(FMT_FP32, 28'h4000004, 8'd0, 8'd127, 0, 0, 0, 0, 32'h3F800000, 3'b000, 3'b001);
    tbl[3]  = vec(FMT_FP32, 28'h7FFFFFC, 8'd0, 8'd127, 0, 0, 0, 0, 32'h40000000, 3'b000, 3'b001);
    tbl[4]  = vec(FMT_FP32, 28'h8000000, 8'd0, 8'd254, 0, 0, 0, 0, 32'h7F800000, 3'b000, 3'b101);
    tbl[5]  = vec(FMT_FP32, 28'h0000000, 8'd0, 8'd127, 0, 1, 0, 0, 32'h80000000, 3'b000, 3'b000);
    tbl[6]  = vec(FMT_FP16, {14'h1000, 14'h0800}, 8'd15, 8'd1, 0, 0, 0, 0,
                  32'h3C000000, 3'b000, 3'b011);
    tbl[7]  = vec(FMT_FP16, {14'h2000, 14'h1001}, 8'd30, 8'd15, 1, 0, 0, 0,
                  32'hFC003C00, 3'b101, 3'b001);
    tbl[8]  = vec(FMT_FP32, 28'h4000000, 8'd0, 8'd127, 0, 0, 0, 1, 32'h3F800000, 3'b000, 3'b001);
    tbl[9]  = vec(FMT_FP32, 28'h2000000, 8'd0, 8'd1, 0, 0, 0, 0, 32'h00000000, 3'b000, 3'b011);
    tbl[10] = vec(FMT_FP16, {14'h0000, 14'h1006}, 8'd9, 8'd15, 1, 0, 0, 0,
                  32'h80003C02, 3'b000, 3'b001);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.fmt       = FMT_FP32;
    bus.X         = 28'd0;
    bus.exp_h     = 8'd0;
    bus.exp_l     = 8'd0;
    bus.sign_h    = 1'b0;
    bus.sign_l    = 1'b0;
    bus.Sticky_h  = 1'b0;
    bus.Sticky_l  = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset:out_valid", bus.out_valid, 1'b0);
    chk("reset:in_ready", bus.in_ready, 1'b1);
    chk("reset:R", bus.R, 32'd0);
    chk("reset:flags", {bus.flags_h, bus.flags_l}, 6'd0);
    rst = 1'b0;

    // Fixed vectors, one at a time, with latency checked
    chk_lat = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tag = $sformatf("vec%0d", i);
      stimq.push_back(tbl[i]);
      run_until_empty(20);
    end

    // Backpressure: five beats offered against a stalled consumer
    tag     = "bp";
    chk_lat = 1'b0;
    or_val  = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) stimq.push_back(mk_rand());
    repeat (4) cycle();
    chk("bp:accepted", 64'(acc_cnt), 64'(LAT));
    chk("bp:in_ready", bus.in_ready, 1'b0);
    or_val = 1'b1;
    run_until_empty(40);

    // Mid-stream reset with two beats in flight
    tag    = "rst";
    or_val = 1'b0;
    for (int i = 0; i < 2; i++) stimq.push_back(mk_rand());
    repeat (2) cycle();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst:out_valid", bus.out_valid, 1'b0);
    chk("rst:in_ready", bus.in_ready, 1'b1);
    chk("rst:R", bus.R, 32'd0);
    chk("rst:flags", {bus.flags_h, bus.flags_l}, 6'd0);
    expq.delete();
    stimq.delete();
    stall_prev = 1'b0;
    or_val     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rst:no_stale", bus.out_valid, 1'b0);
    end
    tag     = "rst_after";
    chk_lat = 1'b1;
    stimq.push_back(tbl[7]);
    run_until_empty(20);

    // Randomized traffic with random gaps and stalls
    tag     = "rand";
    chk_lat = 1'b0;
    gap_pct = 25;
    for (int i = 0; i < 400; i++) stimq.push_back(mk_rand());
    for (int n = 0; n < 6000 && (stimq.size() != 0 || expq.size() != 0); n++) begin
      or_val = ($urandom_range(0, 3) != 0);
      cycle();
    end
    or_val  = 1'b1;
    gap_pct = 0;
    run_until_empty(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
